// File: rtl/fifo_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl_pkg
// Shared definitions for the FIFO write-side controller:
//   - state_t      : controller state (INIT, RUN)
//   - INIT_LAST    : final value of the INIT cycle counter (counts 0..2)
//   - bin2gray     : binary -> Gray conversion (32-bit container, zero-extend
//                    narrower pointers and truncate the result)
//   - gray2bin     : Gray -> binary conversion (same container convention)
// -----------------------------------------------------------------------------
package fifo_wr_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] INIT_LAST = 2'd2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; upper zero bits of a narrower pointer do
  // not disturb the lower result bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// Two-flop synchronizer for a Gray-coded pointer crossing into sys_clk.
// Only one bit changes per pointer step, so each captured word is either the
// old or the new pointer value.
//   sys_clk    in   destination clock
//   sys_rst_n  in   asynchronous active-low reset (flops clear to 0)
//   d          in   WIDTH  pointer from the foreign clock domain
//   q          out  WIDTH  synchronized pointer (2 cycles of latency)
// -----------------------------------------------------------------------------
module ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      // stage 0: first capture (may go metastable)
      meta_p0 <= d;
      // stage 1: settled copy
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO. Owns the binary write
// pointer, drives the RAM write port, publishes a Gray-coded write pointer to
// the read domain and derives occupancy / full from a synchronized copy of
// the read pointer. After reset release the block spends 3 cycles in INIT
// (reporting full, ignoring requests) before accepting writes.
//
// Optional feature: define FIFO_WR_AF_EN to add the almost_full output.
//
// Parameters
//   ADDR_WIDTH  RAM address width, DEPTH = 2**ADDR_WIDTH
//   AF_THRESH   free-slot count at or below which almost_full asserts
// Ports
//   sys_clk      in   1             clock, rising edge
//   sys_rst_n    in   1             asynchronous active-low reset
//   wr_req       in   1             write request
//   wr_ack       out  1             write accepted this cycle
//   ram_we       out  1             RAM write enable
//   ram_waddr    out  ADDR_WIDTH    RAM write address
//   rd_ptr_gray  in   ADDR_WIDTH+1  Gray read pointer (foreign clock)
//   wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer
//   full         out  1             no free slot (also held high in INIT)
//   almost_full  out  1             free slots <= AF_THRESH (FIFO_WR_AF_EN)
//   wr_count     out  ADDR_WIDTH+1  occupancy seen from the write side
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_req,
  output logic                  wr_ack,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
`ifdef FIFO_WR_AF_EN
  output logic                  almost_full,
`endif
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t         state, state_nxt;
  logic [1:0]     init_cnt, init_cnt_nxt;
  logic           in_run;

  logic [PW-1:0]  wr_bin, wr_bin_nxt;
  logic [PW-1:0]  wr_gray_nxt;
  logic [PW-1:0]  rd_gray_sync;
  logic [PW-1:0]  rd_bin_s;

  // ---------------------------------------------------------------------------
  // Control FSM: INIT for cycles 0..2 after reset release, then RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= INIT;
      init_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = RUN;
        end else begin
          init_cnt_nxt = init_cnt + 2'd1;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign in_run = (state == RUN);

  // ---------------------------------------------------------------------------
  // Read-pointer crossing: 2-flop sync, then registered Gray -> binary
  // ---------------------------------------------------------------------------
  ptr_sync #(
    .WIDTH (PW)
  ) u_rd_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (rd_ptr_gray),
    .q         (rd_gray_sync)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_bin_s <= '0;
    end else begin
      rd_bin_s <= PW'(gray2bin(32'(rd_gray_sync)));
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy and write acceptance (combinational from registered state).
  // The read pointer is at least 3 cycles stale, so full can only linger,
  // never clear early.
  // ---------------------------------------------------------------------------
  assign wr_count  = wr_bin - rd_bin_s;
  assign full      = ~in_run | (wr_count == PW'(DEPTH));
  assign wr_ack    = in_run & wr_req & ~full;
  assign ram_we    = wr_ack;
  assign ram_waddr = wr_bin[ADDR_WIDTH-1:0];

`ifdef FIFO_WR_AF_EN
  logic [PW-1:0] free_slots;
  assign free_slots  = PW'(DEPTH) - wr_count;
  assign almost_full = ~in_run | (free_slots <= PW'(AF_THRESH));
`endif

  // ---------------------------------------------------------------------------
  // Write pointer: Gray copy is computed from the next binary value so both
  // registers change on the same edge.
  // ---------------------------------------------------------------------------
  assign wr_bin_nxt  = wr_bin + {{(PW-1){1'b0}}, wr_ack};
  assign wr_gray_nxt = PW'(bin2gray(32'(wr_bin_nxt)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
    end else begin
      wr_bin      <= wr_bin_nxt;
      wr_ptr_gray <= wr_gray_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl with ADDR_WIDTH=3, AF_THRESH=2.
// A behavioural model (write count, INIT countdown, 3-deep history of the
// read pointer) predicts every output on every falling edge; directed
// sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int AF    = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          wr_req = 1'b0;
  logic          wr_ack;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [PW-1:0] rd_ptr_gray = '0;
  logic [PW-1:0] wr_ptr_gray;
  logic          full;
  logic [PW-1:0] wr_count;
`ifdef FIFO_WR_AF_EN
  logic          almost_full;
`endif

  fifo_wr_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
`ifdef FIFO_WR_AF_EN
    .almost_full (almost_full),
`endif
    .wr_count    (wr_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int            m_wr   = 0;   // total accepted writes since reset
  int            m_init = 3;   // INIT cycles still to go
  logic [PW-1:0] h0 = '0, h1 = '0, h2 = '0;  // read pointer seen 1/2/3 edges ago

  function automatic int g2b(input logic [PW-1:0] g);
    int b = 0;
    for (int i = 0; i < PW; i++) b = b | (int'(^(g >> i)) << i);
    return b;
  endfunction

  function automatic int gray_of(input int b);
    return (b & 15) ^ ((b & 15) >> 1);
  endfunction

  function automatic int exp_count();
    return (m_wr - g2b(h2)) & 15;
  endfunction

  function automatic bit exp_full();
    return (m_init > 0) || (exp_count() == DEPTH);
  endfunction

  function automatic bit exp_ack();
    return sys_rst_n && (m_init == 0) && wr_req && !exp_full();
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_wr = 0; m_init = 3; h0 = '0; h1 = '0; h2 = '0;
    end else begin
      if (m_init > 0) m_init--;
      else if (exp_ack()) m_wr++;
      h2 = h1; h1 = h0; h0 = rd_ptr_gray;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  bit            cmp_en  = 1'b0;
  bit            in_wrap = 1'b0;
  bit            saw_wrap = 1'b0;
  logic [PW-1:0] prev_gray = '0;

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("m_wr_ack",   wr_ack,    exp_ack());
      chk("m_ram_we",   ram_we,    exp_ack());
      chk("m_waddr",    ram_waddr, m_wr & 7);
      chk("m_wr_gray",  wr_ptr_gray, gray_of(m_wr));
      chk("m_full",     full,      exp_full());
      chk("m_wr_count", wr_count,  exp_count());
`ifdef FIFO_WR_AF_EN
      chk("m_almost_full", almost_full, (m_init > 0) || ((DEPTH - exp_count()) <= AF));
`endif
      if (in_wrap) begin
        chk("wrap_no_false_full", full, 0);
        if (wr_ptr_gray !== prev_gray)
          chk("gray_one_bit", $countones(wr_ptr_gray ^ prev_gray), 1);
        if (prev_gray == 4'b1000 && wr_ptr_gray !== prev_gray) begin
          chk("gray_wrap_to_zero", wr_ptr_gray, 4'b0000);
          saw_wrap = 1'b1;
        end
      end
      prev_gray = wr_ptr_gray;
    end
  end

  task automatic after_pos();
    @(posedge sys_clk); #1;
  endtask

  task automatic after_neg();
    @(negedge sys_clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   wr_ack, 0);
    chk({tag, "_we"},    ram_we, 0);
    chk({tag, "_waddr"}, ram_waddr, 0);
    chk({tag, "_gray"},  wr_ptr_gray, 0);
    chk({tag, "_count"}, wr_count, 0);
    chk({tag, "_full"},  full, 1);
`ifdef FIFO_WR_AF_EN
    chk({tag, "_af"},    almost_full, 1);
`endif
  endtask

  // INIT window after release: no ack on cycles 0..2, first ack on cycle 3
  task automatic chk_init_window(input string tag);
    for (int c = 0; c <= 3; c++) begin
      after_neg();
      chk({tag, "_init_ack"}, wr_ack, (c == 3) ? 1 : 0);
    end
    chk({tag, "_first_waddr"}, ram_waddr, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit hit;
    #1 sys_rst_n = 1'b0;
    cmp_en = 1'b1;
    #1 chk_reset_vals("reset");

    // Reset release with wr_req held high
    wr_req = 1'b1;
    after_pos();
    after_pos();
    sys_rst_n = 1'b1;
    chk_init_window("rel");        // ends in cycle 3

    // Eight back-to-back writes: cycles 3..10, addresses 0..7
    for (int c = 4; c <= 12; c++) begin
      after_neg();
      if (c <= 10) chk("burst_waddr", ram_waddr, c - 3);
`ifdef FIFO_WR_AF_EN
      if (c == 8) chk("af_at_5", almost_full, 0);
      if (c == 9) chk("af_at_6", almost_full, 1);
`endif
      if (c >= 11) begin
        chk("ninth_ack",  wr_ack, 0);
        chk("ninth_we",   ram_we, 0);
        chk("full_at_8",  full, 1);
        chk("count_8",    wr_count, 8);
        chk("gray_at_8",  wr_ptr_gray, 4'b1100);
      end
    end

    // Read pointer 0 -> 1: full holds for exactly 3 edges
    wr_req = 1'b0;
    after_pos();
    rd_ptr_gray = 4'b0001;
    for (int k = 0; k <= 3; k++) begin
      after_neg();
      chk("full_release", full, (k == 3) ? 0 : 1);
    end
    chk("count_7", wr_count, 7);

    // Wrap: reader keeps pace one word behind the writer
    after_pos();
    rd_ptr_gray = PW'(gray_of(7));
    repeat (3) after_pos();
    in_wrap = 1'b1;
    wr_req  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      after_pos();
      rd_ptr_gray = PW'(gray_of(m_wr - 1));
    end
    wr_req = 1'b0;
    after_neg();
    in_wrap = 1'b0;
    chk("wrap_seen", saw_wrap, 1);

    // Reset in the middle of a burst at wr_count = 5
    after_pos();
    sys_rst_n = 1'b0;
    rd_ptr_gray = '0;
    after_pos();
    sys_rst_n = 1'b1;
    wr_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      after_pos();
      if (m_wr == 5) hit = 1'b1;
    end
    chk("reach_count_5", hit, 1);
    chk("inflight_we", ram_we, 1);
    sys_rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    after_pos();
    chk("midrst_edge_we", ram_we, 0);
    sys_rst_n = 1'b1;
    chk_init_window("rerel");

    wr_req = 1'b0;
    repeat (3) after_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
